// File: rtl/emio_reg_pkg.sv
// Shared constants for the EMIO GPIO register responder:
// bus bit positions, register addresses and FSM states.
package emio_reg_pkg;

    localparam int WDATA_LSB = 0;
    localparam int ADDR_LSB  = 32;
    localparam int WE_BIT    = 40;
    localparam int REQ_BIT   = 41;
    localparam int ACK_BIT   = 32;
    localparam int ERR_BIT   = 33;

    localparam logic [7:0] ADDR_ID      = 8'h00;
    localparam logic [7:0] ADDR_LED     = 8'h01;
    localparam logic [7:0] ADDR_SW      = 8'h02;
    localparam logic [7:0] ADDR_SCRATCH = 8'h03;
    localparam logic [7:0] ADDR_CNT     = 8'h04;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        CAPTURE,
        EXEC,
        RESP
    } state_t;

endpackage

// File: rtl/emio_reg_responder_if.sv
// PS7 EMIO GPIO bank as seen from the PL.
// master = PS side, slave = PL responder.
interface emio_reg_responder_if;

    logic [63:0] gpio_o;
    logic [63:0] gpio_t;
    logic [63:0] gpio_i;

    modport master (
        output gpio_o,
        output gpio_t,
        input  gpio_i
    );

    modport slave (
        input  gpio_o,
        input  gpio_t,
        output gpio_i
    );

endinterface

// File: rtl/emio_sync.sv
// Multi-flop synchronizer chain with synchronous reset.
// STAGES must be at least 2.
module emio_sync #(
    parameter int W      = 1,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [STAGES-1:0][W-1:0] chain;

    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/emio_reg_responder.sv
// PL register responder driven by PS software over EMIO GPIO
// using a req/ack toggle handshake.
module emio_reg_responder
    import emio_reg_pkg::*;
#(
    parameter logic [31:0] ID_VALUE    = 32'h475A_0001,
    parameter int          LED_W       = 4,
    parameter int          SW_W        = 2,
    parameter int          SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    emio_reg_responder_if.slave emio,
    input  logic [SW_W-1:0]  sw,
    output logic [LED_W-1:0] led
);

    localparam int CW = $clog2(SYNC_STAGES + 1) + 1;
    localparam logic [CW-1:0] INIT_LAST = CW'(SYNC_STAGES);

    logic            req_s;
    logic [SW_W-1:0] sw_s;

    state_t          state_q;
    state_t          state_d;
    logic [CW-1:0]   init_cnt_q;

    logic            init_done;
    logic            do_capture;
    logic            do_exec;
    logic            do_resp;

    logic            ack_q;
    logic            err_q;
    logic [31:0]     rdata_q;

    logic [7:0]      addr_q;
    logic            we_q;
    logic [31:0]     wdata_q;

    logic [LED_W-1:0] led_q;
    logic [31:0]      scratch_q;
    logic [31:0]      cnt_q;

    logic            hit_id;
    logic            hit_led;
    logic            hit_sw;
    logic            hit_scratch;
    logic            hit_cnt;
    logic [31:0]     rd_data;
    logic            rd_err;

    logic            wr_led;
    logic            wr_scratch;
    logic            wr_cnt;

    wire unused_bits = ^{emio.gpio_t, emio.gpio_o[63:REQ_BIT+1]};

    emio_sync #(
        .W      (1),
        .STAGES (SYNC_STAGES)
    ) u_req_sync (
        .clk (clk),
        .rst (rst),
        .d   (emio.gpio_o[REQ_BIT]),
        .q   (req_s)
    );

    emio_sync #(
        .W      (SW_W),
        .STAGES (SYNC_STAGES)
    ) u_sw_sync (
        .clk (clk),
        .rst (rst),
        .d   (sw),
        .q   (sw_s)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= INIT;
            init_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == INIT && !init_done) begin
                init_cnt_q <= init_cnt_q + CW'(1);
            end
        end
    end

    // INIT waits until the req synchronizer holds a real sample
    // before aligning ack, so a stale req level is not a request.
    always_comb begin
        state_d    = state_q;
        init_done  = 1'b0;
        do_capture = 1'b0;
        do_exec    = 1'b0;
        do_resp    = 1'b0;
        unique case (state_q)
            INIT: begin
                if (init_cnt_q == INIT_LAST) begin
                    init_done = 1'b1;
                    state_d   = IDLE;
                end
            end
            IDLE: begin
                if (req_s != ack_q) begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                do_capture = 1'b1;
                state_d    = EXEC;
            end
            EXEC: begin
                do_exec = 1'b1;
                state_d = RESP;
            end
            RESP: begin
                do_resp = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ack_q <= 1'b0;
        end else if (init_done) begin
            ack_q <= req_s;
        end else if (do_resp) begin
            ack_q <= ~ack_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
        end else if (do_capture) begin
            addr_q  <= emio.gpio_o[ADDR_LSB +: 8];
            we_q    <= emio.gpio_o[WE_BIT];
            wdata_q <= emio.gpio_o[WDATA_LSB +: 32];
        end
    end

    assign hit_id      = (addr_q == ADDR_ID);
    assign hit_led     = (addr_q == ADDR_LED);
    assign hit_sw      = (addr_q == ADDR_SW);
    assign hit_scratch = (addr_q == ADDR_SCRATCH);
    assign hit_cnt     = (addr_q == ADDR_CNT);

    always_comb begin
        rd_data = '0;
        rd_err  = 1'b0;
        unique case (1'b1)
            hit_id:      rd_data = ID_VALUE;
            hit_led:     rd_data = 32'(led_q);
            hit_sw:      rd_data = 32'(sw_s);
            hit_scratch: rd_data = scratch_q;
            hit_cnt:     rd_data = cnt_q;
            default:     rd_err  = 1'b1;
        endcase
    end

    assign wr_led     = do_exec & we_q & hit_led;
    assign wr_scratch = do_exec & we_q & hit_scratch;
    assign wr_cnt     = do_exec & we_q & hit_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (do_exec) begin
            rdata_q <= we_q ? 32'h0 : rd_data;
            err_q   <= rd_err;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            led_q     <= '0;
            scratch_q <= '0;
        end else begin
            if (wr_led) begin
                led_q <= wdata_q[LED_W-1:0];
            end
            if (wr_scratch) begin
                scratch_q <= wdata_q;
            end
        end
    end

    // A clearing write wins over the increment in the same cycle.
    always_ff @(posedge clk) begin
        if (rst || wr_cnt) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    always_comb begin
        emio.gpio_i                = '0;
        emio.gpio_i[31:0]          = rdata_q;
        emio.gpio_i[ACK_BIT]       = ack_q;
        emio.gpio_i[ERR_BIT]       = err_q;
    end

    assign led = led_q;

endmodule

// File: tb/tb_emio_reg_responder.sv
// Directed bench for emio_reg_responder: PS-side handshake driver,
// register-map model and a per-cycle output comparator.
module tb_emio_reg_responder;

    localparam int          SYNC = 2;
    localparam logic [31:0] IDV  = 32'h475A_0001;
    localparam logic [1:0]  SWV  = 2'b10;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] sw;
    logic [3:0] led;

    logic        req   = 1'b0;
    logic        we    = 1'b0;
    logic [7:0]  addr  = 8'h00;
    logic [31:0] wdata = 32'h0;

    int cyc    = 0;
    int errors = 0;
    int checks = 0;

    logic [3:0]  led_m     = 4'h0;
    logic [31:0] scratch_m = 32'h0;
    logic [31:0] exp_rdata = 32'h0;
    logic        exp_err   = 1'b0;
    logic        exp_ack   = 1'b0;
    bit          busy      = 1'b0;
    bit          chk_en    = 1'b0;
    int          last_clr  = 0;

    emio_reg_responder_if emio();

    assign emio.gpio_o = {22'h15A5A5, req, we, addr, wdata};
    assign emio.gpio_t = 64'hF0F0_1234_5678_9ABC;

    emio_reg_responder #(
        .ID_VALUE    (IDV),
        .LED_W       (4),
        .SW_W        (2),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .emio (emio),
        .sw   (sw),
        .led  (led)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("gpio_hi", 64'(emio.gpio_i[63:34]), 64'h0);
            if (!busy) begin
                chk("ack", 64'(emio.gpio_i[32]), 64'(exp_ack));
                chk("rdata", 64'(emio.gpio_i[31:0]), 64'(exp_rdata));
                chk("err", 64'(emio.gpio_i[33]), 64'(exp_err));
                chk("led", 64'(led), 64'(led_m));
            end
        end
    end

    task automatic xact(input logic [7:0] a, input logic w,
                        input logic [31:0] d, output int t_ack);
        int          c0;
        bit          done;
        logic [31:0] r;
        logic        e;
        @(posedge clk); #1;
        addr  = a;
        we    = w;
        wdata = d;
        r = 32'h0;
        e = 1'b0;
        case (a)
            8'h00: r = IDV;
            8'h01: if (w) led_m = d[3:0]; else r = {28'h0, led_m};
            8'h02: r = {30'h0, SWV};
            8'h03: if (w) scratch_m = d; else r = scratch_m;
            8'h04: r = 32'h0;
            default: e = 1'b1;
        endcase
        if (w) r = 32'h0;
        busy    = 1'b1;
        req     = ~req;
        exp_ack = req;
        c0      = cyc;
        done    = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (emio.gpio_i[32] == req) begin
                done = 1'b1;
                break;
            end
        end
        t_ack = cyc;
        chk("ack_timeout", 64'(done), 64'h1);
        chk("latency", 64'(t_ack - c0), 64'(SYNC + 4));
        if (a == 8'h04) begin
            if (w) last_clr = t_ack - 1;
            else r = 32'(t_ack - 1 - last_clr - 1);
        end
        exp_rdata = r;
        exp_err   = e;
        busy      = 1'b0;
    endtask

    initial begin
        int t, t1, t2;
        logic [31:0] v1;
        rst = 1'b1;
        sw  = SWV;
        repeat (5) @(posedge clk);
        #1;
        chk("rst_gpio_i", emio.gpio_i, 64'h0);
        chk("rst_led", 64'(led), 64'h0);
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("init_ack", 64'(emio.gpio_i[32]), 64'h0);
        chk_en = 1'b1;

        xact(8'h00, 1'b0, 32'h0, t);
        chk("id_lit", 64'(emio.gpio_i[31:0]), 64'h475A0001);
        chk("id_ack_lit", 64'(emio.gpio_i[32]), 64'h1);

        xact(8'h01, 1'b1, 32'hFFFF_FFF5, t);
        chk("led_lit", 64'(led), 64'h5);
        xact(8'h01, 1'b0, 32'h0, t);
        chk("led_rd_lit", 64'(emio.gpio_i[31:0]), 64'h5);

        xact(8'h02, 1'b0, 32'h0, t);
        chk("sw_lit", 64'(emio.gpio_i[31:0]), 64'h2);

        xact(8'h03, 1'b1, 32'hDEAD_BEEF, t);
        xact(8'h03, 1'b0, 32'h0, t);
        chk("scr_lit", 64'(emio.gpio_i[31:0]), 64'hDEADBEEF);

        xact(8'h7F, 1'b0, 32'h0, t);
        chk("bad_rd_err_lit", 64'(emio.gpio_i[33]), 64'h1);
        xact(8'h7F, 1'b1, 32'h1, t);
        chk("bad_wr_err_lit", 64'(emio.gpio_i[33]), 64'h1);
        xact(8'h01, 1'b0, 32'h0, t);
        chk("led_kept_lit", 64'(emio.gpio_i[31:0]), 64'h5);
        xact(8'h03, 1'b0, 32'h0, t);
        chk("scr_kept_lit", 64'(emio.gpio_i[31:0]), 64'hDEADBEEF);

        xact(8'h04, 1'b1, 32'h1234, t);
        xact(8'h04, 1'b0, 32'h0, t1);
        chk("cnt_lit", 64'(emio.gpio_i[31:0]), 64'd6);
        v1 = emio.gpio_i[31:0];
        xact(8'h04, 1'b0, 32'h0, t2);
        chk("cnt_diff_lit", 64'(emio.gpio_i[31:0] - v1), 64'd7);
        chk("cnt_diff", 64'(emio.gpio_i[31:0] - v1), 64'(t2 - t1));

        xact(8'h00, 1'b0, 32'h0, t);

        @(posedge clk); #1;
        addr  = 8'h01;
        we    = 1'b1;
        wdata = 32'h0000_000F;
        busy  = 1'b1;
        req   = 1'b1;
        repeat (SYNC + 1) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        led_m     = 4'h0;
        scratch_m = 32'h0;
        exp_rdata = 32'h0;
        exp_err   = 1'b0;
        exp_ack   = 1'b1;
        chk("rst_led_lit", 64'(led), 64'h0);
        repeat (SYNC + 3) @(posedge clk);
        #1;
        busy = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        chk("rst_ack_lit", 64'(emio.gpio_i[32]), 64'h1);
        chk("rst_nowr_lit", 64'(led), 64'h0);

        xact(8'h01, 1'b0, 32'h0, t);
        chk("post_rst_led_lit", 64'(emio.gpio_i[31:0]), 64'h0);
        xact(8'h03, 1'b0, 32'h0, t);
        chk("post_rst_scr_lit", 64'(emio.gpio_i[31:0]), 64'h0);

        repeat (3) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
